// File: rtl/regctx_engine.sv
// ---------------------------------------------------------------------------
// regctx_engine
//
// Register context save/restore engine. It walks a 16-bit register mask in
// ascending order and moves one register per step between the on-core
// register file and data memory. It is used on trap entry/exit and on
// context switch.
//
//   save    (cmd_op_i = 0): regfile -> memory, one memory write per register
//   restore (cmd_op_i = 1): memory -> regfile, one memory read plus one
//                           regfile write per register
//
// Register n is always kept in the fixed slot base + n*(WORD_LEN/8), so a
// partially masked save/restore pair uses the same memory layout. Address
// arithmetic wraps modulo 2^ADDR_LEN.
//
// Parameters
//   WORD_LEN   regfile word width and memory data width (default 64)
//   ADDR_LEN   memory byte-address width (default 64)
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only while idle)
//   cmd_op_i                  0 = save, 1 = restore
//   cmd_mask_i                bit n selects register n (G0..G7 = 0..7,
//                             A0..A7 = 8..15)
//   cmd_base_i                context block base byte address
//   busy_o                    command in progress
//   done_o                    one-cycle completion pulse
//   rf_write_en_o             regfile write strobe
//   rf_reg_id_o               regfile register select (read and write)
//   rf_value_o                regfile write data
//   rf_value_i                regfile read data, combinational from
//                             rf_reg_id_o
//   mem_req_o/mem_gnt_i       memory request handshake
//   mem_we_o                  1 = write, 0 = read
//   mem_addr_o/mem_wdata_o    memory byte address / write data
//   mem_rvalid_i/mem_rdata_i  memory read response
//   csum_o                    (REGCTX_CHECKSUM_EN only) XOR of every word
//                             moved by the current/last command
//
// Build option
//   REGCTX_CHECKSUM_EN  when defined, adds csum_o and its accumulator. When
//                       undefined the port and logic are absent.
// ---------------------------------------------------------------------------
module regctx_engine #(
  parameter int WORD_LEN = 64,
  parameter int ADDR_LEN = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_op_i,
  input  logic [15:0]         cmd_mask_i,
  input  logic [ADDR_LEN-1:0] cmd_base_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                rf_write_en_o,
  output logic [3:0]          rf_reg_id_o,
  output logic [WORD_LEN-1:0] rf_value_o,
  input  logic [WORD_LEN-1:0] rf_value_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [WORD_LEN-1:0] mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [WORD_LEN-1:0] mem_rdata_i
`ifdef REGCTX_CHECKSUM_EN
  ,
  output logic [WORD_LEN-1:0] csum_o
`endif
);

  localparam int WORD_BYTES = WORD_LEN / 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT_RD,
    WB,
    DONE
  } state_t;

  state_t              state;
  logic                op_q;
  logic [15:0]         rem_q;
  logic [ADDR_LEN-1:0] base_q;
  logic [3:0]          idx_q;

  logic [3:0]          scan_idx;
  logic [15:0]         rem_cleared;
  logic [ADDR_LEN-1:0] slot_addr;

  // Index of the lowest set bit; ascending register order falls out of
  // always picking the lowest remaining bit.
  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign scan_idx    = lowest_set(rem_q);
  assign rem_cleared = rem_q & ~(16'h0001 << idx_q);
  assign slot_addr   = base_q + ADDR_LEN'(scan_idx) * ADDR_LEN'(WORD_BYTES);

  // Save data is the live regfile read port: rf_reg_id_o is already stable
  // from SCAN, so the word stays constant for as long as the request stalls.
  assign mem_wdata_o = (state == REQ && !op_q) ? rf_value_i : '0;

  // Control FSM. Every output except mem_wdata_o is registered and is set
  // on the transition into the state that owns it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      op_q          <= 1'b0;
      rem_q         <= '0;
      base_q        <= '0;
      idx_q         <= '0;
      cmd_ready_o   <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      rf_write_en_o <= 1'b0;
      rf_reg_id_o   <= '0;
      rf_value_o    <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q        <= cmd_op_i;
            rem_q       <= cmd_mask_i;
            base_q      <= cmd_base_i;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            // An empty mask has nothing to move and completes at once.
            if (cmd_mask_i == 16'h0000) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= SCAN;
            end
          end
        end

        SCAN: begin
          idx_q       <= scan_idx;
          rf_reg_id_o <= scan_idx;
          mem_req_o   <= 1'b1;
          mem_we_o    <= ~op_q;
          mem_addr_o  <= slot_addr;
          state       <= REQ;
        end

        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            if (!op_q) begin
              // Save: the write is complete once granted.
              rem_q <= rem_cleared;
              if (rem_cleared == 16'h0000) begin
                done_o <= 1'b1;
                state  <= DONE;
              end else begin
                state  <= SCAN;
              end
            end else begin
              state <= WAIT_RD;
            end
          end
        end

        WAIT_RD: begin
          if (mem_rvalid_i) begin
            rf_value_o    <= mem_rdata_i;
            rf_write_en_o <= 1'b1;
            state         <= WB;
          end
        end

        WB: begin
          rf_write_en_o <= 1'b0;
          rem_q         <= rem_cleared;
          if (rem_cleared == 16'h0000) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            state  <= SCAN;
          end
        end

        DONE: begin
          done_o      <= 1'b0;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef REGCTX_CHECKSUM_EN
  logic [WORD_LEN-1:0] csum_q;

  // Running XOR of moved words. Save words are taken as they are granted,
  // restore words as they are written back (rf_value_o holds the latched
  // read data during WB). The value holds after DONE until the next accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csum_q <= '0;
    end else if (state == IDLE && cmd_valid_i) begin
      csum_q <= '0;
    end else if (state == REQ && mem_gnt_i && !op_q) begin
      csum_q <= csum_q ^ rf_value_i;
    end else if (state == WB) begin
      csum_q <= csum_q ^ rf_value_o;
    end
  end

  assign csum_o = csum_q;
`endif

endmodule

// File: tb/tb_regctx_engine.sv
// ---------------------------------------------------------------------------
// tb_regctx_engine
//
// Scoreboard bench for regctx_engine. Each command is expanded by a
// reference model into the list of memory transactions, regfile writes and
// the completion event it must produce; a monitor pops and compares those as
// the DUT presents them. A reactive memory responder supplies grants and read
// data with configurable or random delays.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regctx_engine;

  logic        clk;
  logic        reset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_op_i;
  logic [15:0] cmd_mask_i;
  logic [63:0] cmd_base_i;
  logic        busy_o;
  logic        done_o;
  logic        rf_write_en_o;
  logic [3:0]  rf_reg_id_o;
  logic [63:0] rf_value_o;
  logic [63:0] rf_value_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
`ifdef REGCTX_CHECKSUM_EN
  logic [63:0] csum_o;
`endif

  regctx_engine #(.WORD_LEN(64), .ADDR_LEN(64)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_mask_i   (cmd_mask_i),
    .cmd_base_i   (cmd_base_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rf_write_en_o(rf_write_en_o),
    .rf_reg_id_o  (rf_reg_id_o),
    .rf_value_o   (rf_value_o),
    .rf_value_i   (rf_value_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef REGCTX_CHECKSUM_EN
    ,
    .csum_o       (csum_o)
`endif
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_evt_t;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] value;
  } rf_evt_t;

  typedef struct {
    int          lat;
    logic [63:0] csum;
  } done_evt_t;

  mem_evt_t  memQ[$];
  rf_evt_t   rfQ[$];
  done_evt_t doneQ[$];

  logic [63:0] rfModel [16];
  logic [63:0] salt;
  bit          useFixedData;
  logic [63:0] fixedData;
  int          stallFixed;
  int          stallMax;
  int          rvFixed;
  int          rvMax;
  bit          strayRvalid;

  int numChecks;
  int numFails;
  int cyc;
  int acceptCyc;
  int rfWriteCount;

  assign rf_value_i = rfModel[rf_reg_id_o];

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure command latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Contents of the memory model: a fixed word when a directed test asks
  // for one, otherwise a scrambled function of the address.
  function automatic logic [63:0] memFn(input logic [63:0] addr);
    if (useFixedData) return fixedData;
    return {addr[31:0] * 32'h9E37_79B1, ~addr[31:0]} ^ salt;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flagUnexpected(input string name);
    numChecks++;
    numFails++;
    $display("[TB] FAIL %s actual=unexpected-event expected=none (t=%0t)", name, $time);
  endtask

  // Memory responder: grants after a chosen stall, returns read data after a
  // chosen delay, drops outstanding reads on reset, and can inject a stray
  // rvalid pulse on request.
  initial begin : responder
    bit          sReset, sReq, sGnt, sWe;
    logic [63:0] sAddr, rdAddr;
    bit          rdPending, reqActive;
    int          rdDelay, stallLeft;
    rdPending = 0; reqActive = 0; rdDelay = 0; stallLeft = 0; rdAddr = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      sReset = reset_i; sReq = mem_req_o; sGnt = mem_gnt_i;
      sWe = mem_we_o; sAddr = mem_addr_o;
      #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (sReset) begin
        rdPending = 0;
        reqActive = 0;
      end else begin
        if (sReq && sGnt) begin
          reqActive = 0;
          if (!sWe) begin
            rdPending = 1;
            rdAddr    = sAddr;
            rdDelay   = (rvFixed >= 0) ? rvFixed : $urandom_range(rvMax, 0);
          end
        end
        if (rdPending) begin
          if (rdDelay == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memFn(rdAddr);
            rdPending    = 0;
          end else begin
            rdDelay--;
          end
        end
      end
      if (strayRvalid) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      mem_gnt_i = 1'b0;
      if (mem_req_o && !reset_i) begin
        if (!reqActive) begin
          reqActive = 1;
          stallLeft = (stallFixed >= 0) ? stallFixed : $urandom_range(stallMax, 0);
        end
        if (stallLeft == 0) mem_gnt_i = 1'b1;
        else stallLeft--;
      end
    end
  end

  // Monitor: compares every DUT-presented transaction with the head of the
  // matching scoreboard queue. Memory requests are compared every cycle they
  // are held, so any change during a stall shows up; the entry is popped on
  // grant.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (mem_req_o) begin
        if (memQ.size() == 0) begin
          flagUnexpected("mem_req");
        end else begin
          checkOutput("mem_we", 64'(mem_we_o), 64'(memQ[0].we));
          checkOutput("mem_addr", mem_addr_o, memQ[0].addr);
          if (memQ[0].we) checkOutput("mem_wdata", mem_wdata_o, memQ[0].wdata);
          if (mem_gnt_i) void'(memQ.pop_front());
        end
      end
      if (rf_write_en_o) begin
        rfWriteCount++;
        if (rfQ.size() == 0) begin
          flagUnexpected("rf_write");
        end else begin
          checkOutput("rf_reg_id", 64'(rf_reg_id_o), 64'(rfQ[0].id));
          checkOutput("rf_value", rf_value_o, rfQ[0].value);
          void'(rfQ.pop_front());
        end
      end
      if (done_o) begin
        if (doneQ.size() == 0) begin
          flagUnexpected("done");
        end else begin
          if (doneQ[0].lat >= 0)
            checkOutput("done_latency", 64'(cyc - acceptCyc), 64'(doneQ[0].lat));
          checkOutput("done_queues_empty", 64'(memQ.size() + rfQ.size()), 64'd0);
`ifdef REGCTX_CHECKSUM_EN
          checkOutput("csum", csum_o, doneQ[0].csum);
`endif
          void'(doneQ.pop_front());
        end
      end
    end
  end

  // Reference model plus command handshake. Expected traffic is derived from
  // the mask directly: each set bit n, lowest first, moves one word at slot
  // base + 8n. When timed is set (no stalls), completion must land at cycle
  // 1 for an empty mask, 2N+1 for save and 4N+1 for restore.
  task automatic applyStimulus(input bit op, input logic [15:0] mask,
                               input logic [63:0] base, input bit timed);
    int          n, nregs, lat;
    logic [63:0] addr, d, csum;
    n = 0;
    while (!cmd_ready_o && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready_o) flagUnexpected("cmd_ready_timeout");
    csum = '0;
    for (int r = 0; r < 16; r++) begin
      if (mask[r]) begin
        addr = base + 64'(r) * 64'd8;
        if (!op) begin
          memQ.push_back('{1'b1, addr, rfModel[r]});
          csum ^= rfModel[r];
        end else begin
          d = memFn(addr);
          memQ.push_back('{1'b0, addr, 64'h0});
          rfQ.push_back('{4'(r), d});
          csum ^= d;
        end
      end
    end
    nregs = $countones(mask);
    if (!timed) lat = -1;
    else if (nregs == 0) lat = 1;
    else lat = op ? (4 * nregs + 1) : (2 * nregs + 1);
    doneQ.push_back('{lat, csum});
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_mask_i  = mask;
    cmd_base_i  = base;
    @(posedge clk); #1;
    acceptCyc   = cyc - 1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 1'b0;
    cmd_mask_i  = '0;
    cmd_base_i  = '0;
  endtask

  task automatic flushQueues();
    memQ.delete();
    rfQ.delete();
    doneQ.delete();
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!(memQ.size() == 0 && rfQ.size() == 0 && doneQ.size() == 0 && cmd_ready_o)) begin
      @(posedge clk); #1; n++;
      if (n > 3000) begin
        numChecks++;
        numFails++;
        $display("[TB] FAIL %s actual=timeout expected=completion (t=%0t)", name, $time);
        flushQueues();
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic setMemTiming(input int sFix, input int sMax, input int rFix, input int rMax);
    stallFixed = sFix; stallMax = sMax; rvFixed = rFix; rvMax = rMax;
  endtask

  // Global bound on simulation time.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [63:0] base;
    int          wrBefore, n;
    numChecks = 0; numFails = 0; cyc = 0; acceptCyc = 0; rfWriteCount = 0;
    salt = {$urandom, $urandom};
    useFixedData = 0; fixedData = '0; strayRvalid = 0;
    setMemTiming(0, 0, 0, 0);
    for (int r = 0; r < 16; r++) rfModel[r] = {$urandom, $urandom};
    reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 1'b0;
    cmd_mask_i = '0; cmd_base_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Reset state
    checkOutput("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_done", 64'(done_o), 64'd0);
    checkOutput("reset_rf_we", 64'(rf_write_en_o), 64'd0);
    checkOutput("reset_rf_id", 64'(rf_reg_id_o), 64'd0);
    checkOutput("reset_rf_value", rf_value_o, 64'd0);
    checkOutput("reset_mem_req", 64'(mem_req_o), 64'd0);
    checkOutput("reset_mem_we", 64'(mem_we_o), 64'd0);
    checkOutput("reset_mem_addr", mem_addr_o, 64'd0);
    checkOutput("reset_mem_wdata", mem_wdata_o, 64'd0);

    // Save of G0 and G2 with immediate grants
    $display("[TB] directed: save mask 0005");
    rfModel[0] = 64'h11; rfModel[2] = 64'h22;
    applyStimulus(1'b0, 16'h0005, 64'h1000, 1'b1);
    checkOutput("busy_during_cmd", 64'(busy_o), 64'd1);
    waitIdle("save_0005");

    // Restore of A7 from a fixed memory word
    $display("[TB] directed: restore mask 8000");
    useFixedData = 1; fixedData = 64'hDEAD;
    applyStimulus(1'b1, 16'h8000, 64'h2000, 1'b1);
    waitIdle("restore_8000");
    useFixedData = 0;

    // Empty mask, both operations
    $display("[TB] directed: empty mask");
    for (int op = 0; op < 2; op++) begin
      wrBefore = rfWriteCount;
      applyStimulus(op[0], 16'h0000, 64'h3000, 1'b1);
      checkOutput("mask0_done_c1", 64'(done_o), 64'd1);
      checkOutput("mask0_ready_c1", 64'(cmd_ready_o), 64'd0);
      checkOutput("mask0_no_req", 64'(mem_req_o), 64'd0);
      @(posedge clk); #1;
      checkOutput("mask0_ready_c2", 64'(cmd_ready_o), 64'd1);
      checkOutput("mask0_done_c2", 64'(done_o), 64'd0);
      checkOutput("mask0_no_rf_write", 64'(rfWriteCount - wrBefore), 64'd0);
      waitIdle("mask0");
    end

    // Save of G1 with a 3-cycle grant stall
    $display("[TB] directed: stalled save mask 0002");
    setMemTiming(3, 0, 0, 0);
    base = {$urandom, $urandom};
    applyStimulus(1'b0, 16'h0002, base, 1'b0);
    waitIdle("stall_0002");
    setMemTiming(0, 0, 0, 0);

    // Reset while a restore waits for read data
    $display("[TB] directed: reset during WAIT_RD");
    setMemTiming(0, 0, 4, 0);
    applyStimulus(1'b1, 16'hFFFF, 64'h4000, 1'b0);
    n = 0;
    while (!(mem_req_o && mem_gnt_i) && n < 50) begin
      @(negedge clk); n++;
    end
    if (!(mem_req_o && mem_gnt_i)) flagUnexpected("reset_test_no_gnt");
    @(posedge clk); #1;
    wrBefore = rfWriteCount;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    flushQueues();
    checkOutput("abort_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("abort_busy", 64'(busy_o), 64'd0);
    checkOutput("abort_mem_req", 64'(mem_req_o), 64'd0);
    strayRvalid = 1;
    @(posedge clk); #1;
    strayRvalid = 0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_no_rf_write", 64'(rfWriteCount - wrBefore), 64'd0);
    checkOutput("abort_still_idle", 64'(busy_o), 64'd0);
    setMemTiming(0, 0, 0, 0);

`ifdef REGCTX_CHECKSUM_EN
    // Checksum over a two-register save
    $display("[TB] directed: checksum save mask 0003");
    rfModel[0] = 64'hF0; rfModel[1] = 64'h0F;
    applyStimulus(1'b0, 16'h0003, 64'h5000, 1'b1);
    waitIdle("csum_0003");
    checkOutput("csum_hold", csum_o, 64'hFF);
`endif

    // Randomized commands with random stalls and read delays
    $display("[TB] random commands");
    setMemTiming(-1, 3, -1, 3);
    for (int k = 0; k < 40; k++) begin
      logic [15:0] m;
      for (int r = 0; r < 16; r++) rfModel[r] = {$urandom, $urandom};
      m = ($urandom_range(7, 0) == 0) ? 16'h0000 : 16'($urandom);
      if (k == 0) base = 64'hFFFF_FFFF_FFFF_FFC0;
      else base = {$urandom, $urandom};
      applyStimulus(1'($urandom), m, base, 1'b0);
      waitIdle("random");
    end

    // Unstalled random commands also check the exact latency
    setMemTiming(0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 16; r++) rfModel[r] = {$urandom, $urandom};
      applyStimulus(k[0], 16'($urandom), {$urandom, $urandom}, 1'b1);
      waitIdle("random_timed");
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
